// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed common-anode seven-segment scan controller.
// Scans NUM_DIGITS digits with frame-synchronous data updates, 8-level
// brightness PWM, per-digit blink and leading-zero blanking.
// an/sseg are active-low and registered.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_LOG2 = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    load,
  input  logic [2:0]              bright,
  input  logic                    lzb,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_done,
  output logic                    upd_pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'(BLINK_FRAMES - 1);

  // Scan timing state
  logic [REFRESH_LOG2-1:0] r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [FC_W-1:0]         r_frame_cnt;
  logic                    r_blink_phase;
  logic                    r_frame_done;

  // Pending (written by load) and active (displayed) register sets
  logic [4*NUM_DIGITS-1:0] r_pend_hex, r_act_hex;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blink, r_act_blink;
  logic                    r_upd_pending;
  logic                    r_act_valid;

  // Output registers
  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_sseg;

  logic                    w_slot_end, w_boundary, w_xfer;
  logic                    w_blink_flip, w_blink_phase;
  logic [4*NUM_DIGITS-1:0] w_hex;
  logic [NUM_DIGITS-1:0]   w_dp, w_blink;
  logic                    w_valid;
  logic [NUM_DIGITS-1:0]   w_digit_zero, w_lz_blank, w_onehot;
  logic [3:0]              w_cur_hex;
  logic                    w_cur_dp, w_cur_blink, w_cur_blank;
  logic [2:0]              w_phase;
  logic                    w_lit;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_an_next;
  logic [7:0]              w_sseg_next;

  assign w_slot_end   = &r_cnt;
  assign w_boundary   = w_slot_end && (r_idx == LAST_IDX);
  assign w_xfer       = w_boundary && r_upd_pending;
  assign w_blink_flip = w_boundary && (r_frame_cnt == LAST_FRAME);
  assign w_blink_phase = r_blink_phase ^ w_blink_flip;

  // The output register loaded on the boundary edge already belongs to the
  // new frame, so it sees the data and blink phase being committed there.
  assign w_hex   = w_xfer ? r_pend_hex   : r_act_hex;
  assign w_dp    = w_xfer ? r_pend_dp    : r_act_dp;
  assign w_blink = w_xfer ? r_pend_blink : r_act_blink;
  assign w_valid = w_xfer || r_act_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_digit_zero[gi] = (w_hex[4*gi +: 4] == 4'd0);
      assign w_onehot[gi]     = (r_idx == IDX_W'(gi));
    end
  endgenerate

  // Leading-zero blank flags: a digit blanks when it and all digits above are zero
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    w_lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero && w_digit_zero[i];
      w_lz_blank[i] = lzb && all_zero;
    end
  end

  // Select the attributes of the digit in the current slot
  always_comb begin
    w_cur_hex   = 4'd0;
    w_cur_dp    = 1'b0;
    w_cur_blink = 1'b0;
    w_cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_onehot[i]) begin
        w_cur_hex   = w_hex[4*i +: 4];
        w_cur_dp    = w_dp[i];
        w_cur_blink = w_blink[i];
        w_cur_blank = w_lz_blank[i];
      end
    end
  end

  // Hex to active-low a..g glyph
  always_comb begin
    w_glyph = 7'b1111111;
    case (w_cur_hex)
      4'h0: w_glyph = 7'b0000001;
      4'h1: w_glyph = 7'b1001111;
      4'h2: w_glyph = 7'b0010010;
      4'h3: w_glyph = 7'b0000110;
      4'h4: w_glyph = 7'b1001100;
      4'h5: w_glyph = 7'b0100100;
      4'h6: w_glyph = 7'b0100000;
      4'h7: w_glyph = 7'b0001111;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0000100;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b1100000;
      4'hC: w_glyph = 7'b0110001;
      4'hD: w_glyph = 7'b1000010;
      4'hE: w_glyph = 7'b0110000;
      default: w_glyph = 7'b0111000;
    endcase
  end

  assign w_phase = r_cnt[REFRESH_LOG2-1 -: 3];
  assign w_lit   = w_valid && (w_phase <= bright) && !(w_blink_phase && w_cur_blink);

  // Next an/sseg: dark slot, blanked digit (dp only), or full glyph
  always_comb begin
    w_an_next   = '1;
    w_sseg_next = 8'hFF;
    if (w_lit) begin
      if (!w_cur_blank) begin
        w_an_next   = ~w_onehot;
        w_sseg_next = {~w_cur_dp, w_glyph};
      end else if (w_cur_dp) begin
        w_an_next   = ~w_onehot;
        w_sseg_next = 8'h7F;
      end
    end
  end

  // Slot counter, digit index, frame pulse and blink phase
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      r_frame_done <= w_boundary;
      if (w_slot_end) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (w_boundary) begin
        r_frame_cnt   <= w_blink_flip ? '0 : r_frame_cnt + 1'b1;
        r_blink_phase <= w_blink_phase;
      end
    end
  end

  // Pending/active sets; a load on the boundary keeps its data pending
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend_hex    <= '0;
      r_pend_dp     <= '0;
      r_pend_blink  <= '0;
      r_act_hex     <= '0;
      r_act_dp      <= '0;
      r_act_blink   <= '0;
      r_act_valid   <= 1'b0;
      r_upd_pending <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_act_hex   <= r_pend_hex;
        r_act_dp    <= r_pend_dp;
        r_act_blink <= r_pend_blink;
        r_act_valid <= 1'b1;
      end
      if (load) begin
        r_pend_hex    <= hex_in;
        r_pend_dp     <= dp_in;
        r_pend_blink  <= blink_en;
        r_upd_pending <= 1'b1;
      end else if (w_xfer) begin
        r_upd_pending <= 1'b0;
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_an   <= '1;
      r_sseg <= 8'hFF;
    end else begin
      r_an   <= w_an_next;
      r_sseg <= w_sseg_next;
    end
  end

  assign an          = r_an;
  assign sseg        = r_sseg;
  assign frame_done  = r_frame_done;
  assign upd_pending = r_upd_pending;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl (4 digits, 16-cycle slots, 2-frame blink).
// Reference model: slot geometry from a cycle count since reset, register
// sets and blink phase from boundary counts.
module tb_sseg_scan_ctrl;

  localparam int N     = 4;
  localparam int RL    = 4;
  localparam int BF    = 2;
  localparam int SLOT  = 1 << RL;
  localparam int FRAME = N * SLOT;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic [15:0]   hex_in   = '0;
  logic [3:0]    dp_in    = '0;
  logic [3:0]    blink_en = '0;
  logic          load     = 1'b0;
  logic [2:0]    bright   = 3'd7;
  logic          lzb      = 1'b0;
  logic [3:0]    an;
  logic [7:0]    sseg;
  logic          frame_done;
  logic          upd_pending;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_LOG2(RL),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blink_en   (blink_en),
    .load       (load),
    .bright     (bright),
    .lzb        (lzb),
    .an         (an),
    .sseg       (sseg),
    .frame_done (frame_done),
    .upd_pending(upd_pending)
  );

  // Reference model state
  int          s;          // cycles since reset release
  int          m_nb;       // frame boundaries since reset
  logic [15:0] m_pend_hex, m_act_hex;
  logic [3:0]  m_pend_dp, m_act_dp, m_pend_blink, m_act_blink;
  bit          m_upd, m_valid;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s s=%0d observed=%02h expected=%02h", tag, s, obs, exp_v);
    end
  endtask

  // Expected pins for a slot at digit idx / PWM phase ph with the model's active set
  task automatic expect_disp(input int idx, input int ph, input int b, input bit z,
                             output logic [3:0] an_e, output logic [7:0] ss_e);
    logic [3:0] digit;
    logic [3:0] oh;
    bit         dp, blank;
    an_e = 4'hF;
    ss_e = 8'hFF;
    oh   = 4'b0001 << idx;
    digit = m_act_hex[idx*4 +: 4];
    dp    = m_act_dp[idx];
    blank = 1'b0;
    if (z && idx >= 1) begin
      blank = 1'b1;
      for (int j = idx; j < N; j++) if (m_act_hex[j*4 +: 4] != 4'd0) blank = 1'b0;
    end
    if (m_valid && ph <= b && !(((m_nb / BF) % 2 == 1) && m_act_blink[idx])) begin
      if (!blank) begin
        an_e = ~oh;
        ss_e = {~dp, GLYPH[digit]};
      end else if (dp) begin
        an_e = ~oh;
        ss_e = 8'h7F;
      end
    end
  endtask

  // Advance one clock, update the model and compare all outputs
  task automatic tick();
    logic [3:0] an_e;
    logic [7:0] ss_e;
    bit         bnd;
    int         idx, ph, b;
    bit         z;
    if (!reset_n) begin
      m_pend_hex = '0; m_pend_dp = '0; m_pend_blink = '0;
      m_act_hex  = '0; m_act_dp  = '0; m_act_blink  = '0;
      m_upd = 1'b0; m_valid = 1'b0; m_nb = 0;
      @(posedge clk); #1;
      s = 0;
      check("rst_an", {4'h0, an}, 8'h0F);
      check("rst_sseg", sseg, 8'hFF);
      check("rst_fd", {7'h0, frame_done}, 8'h00);
      check("rst_upd", {7'h0, upd_pending}, 8'h00);
    end else begin
      bnd = (s % FRAME) == FRAME - 1;
      idx = (s / SLOT) % N;
      ph  = (s % SLOT) / 2;
      b   = int'(bright);
      z   = lzb;
      if (bnd && m_upd) begin
        m_act_hex = m_pend_hex; m_act_dp = m_pend_dp; m_act_blink = m_pend_blink;
        m_valid = 1'b1;
        m_upd   = 1'b0;
      end
      if (load) begin
        m_pend_hex = hex_in; m_pend_dp = dp_in; m_pend_blink = blink_en;
        m_upd = 1'b1;
      end
      if (bnd) m_nb++;
      @(posedge clk); #1;
      s++;
      expect_disp(idx, ph, b, z, an_e, ss_e);
      check("an", {4'h0, an}, {4'h0, an_e});
      check("sseg", sseg, ss_e);
      check("frame_done", {7'h0, frame_done}, {7'h0, bnd});
      check("upd_pending", {7'h0, upd_pending}, {7'h0, m_upd});
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Tick until the next cycle sits at frame offset m (bounded by one frame)
  task automatic run_to(input int m);
    for (int k = 0; k < FRAME && (s % FRAME) != m; k++) tick();
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] bl);
    hex_in   = h;
    dp_in    = d;
    blink_en = bl;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    $display("load hex=%04h dp=%b blink=%b at s=%0d", h, d, bl, s - 1);
  endtask

  function automatic logic [15:0] rand_hex();
    logic [15:0] h;
    for (int i = 0; i < N; i++) h[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
    return h;
  endfunction

  initial begin
    s = 0;
    // 1: reset, then scan order with 0x1234 at full brightness
    reset_n = 1'b0;
    run(3);
    reset_n = 1'b1;
    bright = 3'd7;
    do_load(16'h1234, 4'b0000, 4'b0000);
    run(2 * FRAME);
    $display("step scan order done, s=%0d", s);

    // 2: tear-free update, second load lands while idx=2
    do_load(16'h1234, 4'b0000, 4'b0000);
    run_to(0);
    run_to(2 * SLOT + 3);
    do_load(16'hABCD, 4'b1010, 4'b0000);
    check("upd_after_midload", {7'h0, upd_pending}, 8'h01);
    run(2 * FRAME);
    $display("step tear-free done, s=%0d", s);

    // 3: load on the boundary cycle while 0x1111 is pending
    do_load(16'h1111, 4'b0000, 4'b0000);
    run_to(FRAME - 1);
    do_load(16'h5555, 4'b0001, 4'b0000);
    check("fd_after_bndload", {7'h0, frame_done}, 8'h01);
    check("upd_after_bndload", {7'h0, upd_pending}, 8'h01);
    run(2 * FRAME + 5);
    // boundary load with nothing pending waits a full frame
    run_to(FRAME - 1);
    do_load(16'h9876, 4'b0000, 4'b0000);
    run(2 * FRAME);
    $display("step boundary load done, s=%0d", s);

    // 4: brightness levels
    bright = 3'd1;
    run(FRAME);
    bright = 3'd0;
    run(FRAME);
    bright = 3'd4;
    run(FRAME / 2);
    bright = 3'd7;
    $display("step brightness done, s=%0d", s);

    // 5: leading-zero blanking and blink across two blink periods
    lzb = 1'b1;
    do_load(16'h0040, 4'b0100, 4'b0001);
    run(8 * FRAME);
    do_load(16'h0000, 4'b0000, 4'b0000);
    run(2 * FRAME);
    do_load(16'h0000, 4'b1000, 4'b0000);
    run(2 * FRAME);
    $display("step lzb/blink done, s=%0d", s);

    // randomized traffic
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 15) == 0) bright = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) lzb = ~lzb;
      if ($urandom_range(0, 24) == 0) begin
        hex_in   = rand_hex();
        dp_in    = 4'($urandom_range(0, 15));
        blink_en = 4'($urandom_range(0, 15));
        load     = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    $display("step random done, s=%0d", s);

    // 6: reset while a load is pending in the last slot
    bright = 3'd7;
    lzb = 1'b0;
    run_to(3 * SLOT);
    do_load(16'h7777, 4'b1111, 4'b0000);
    run(4);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("upd_cleared_by_reset", {7'h0, upd_pending}, 8'h00);
    run(2 * FRAME);
    do_load(16'h2468, 4'b0000, 4'b0000);
    run(2 * FRAME);
    $display("step reset mid-operation done, s=%0d", s);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
